// File: rtl/karatsuba_seq.sv
// Sequential Karatsuba multiplier: one (H+1)x(H+1) multiplier is reused for the
// low, high and middle sub-products, then COMBINE assembles the full product.
module karatsuba_seq #(
  parameter  int WIDTH = 16,
  localparam int H     = WIDTH / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Z,
  output logic [2:0]           state_dbg
);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("karatsuba_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_LO    = 3'd1,
    P_HI    = 3'd2,
    P_MID   = 3'd3,
    COMBINE = 3'd4
  } state_t;

  state_t state, state_n;

  logic [H-1:0]     xl, xh, yl, yh;
  logic [2*H-1:0]   z0, z2;
  logic [2*H+1:0]   zm;

  logic [H:0]       mul_a, mul_b;
  logic [2*H+1:0]   prod;
  logic [2*H+1:0]   z1;
  logic [2*WIDTH:0] sum;
  logic             unused_carry;

  // Operand mux feeding the single shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      P_LO: begin
        mul_a = {1'b0, xl};
        mul_b = {1'b0, yl};
      end
      P_HI: begin
        mul_a = {1'b0, xh};
        mul_b = {1'b0, yh};
      end
      P_MID: begin
        mul_a = {1'b0, xl} + {1'b0, xh};
        mul_b = {1'b0, yl} + {1'b0, yh};
      end
      default: ;
    endcase
  end

  assign prod = {{(H+1){1'b0}}, mul_a} * {{(H+1){1'b0}}, mul_b};

  // z1 cannot go negative, and the final sum never carries past 2*WIDTH bits.
  assign z1  = zm - {2'b00, z2} - {2'b00, z0};
  assign sum = {1'b0, z2, {WIDTH{1'b0}}}
             + ({{(WIDTH-1){1'b0}}, z1} << H)
             + {{(WIDTH+1){1'b0}}, z0};
  assign unused_carry = sum[2*WIDTH];

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = P_LO;
      P_LO:    state_n = P_HI;
      P_HI:    state_n = P_MID;
      P_MID:   state_n = COMBINE;
      COMBINE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ready     = (state == IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      xl    <= '0;
      xh    <= '0;
      yl    <= '0;
      yh    <= '0;
      z0    <= '0;
      z2    <= '0;
      zm    <= '0;
      Z     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xl <= X[H-1:0];
            xh <= X[WIDTH-1:H];
            yl <= Y[H-1:0];
            yh <= Y[WIDTH-1:H];
          end
        end
        P_LO:    z0 <= prod[2*H-1:0];
        P_HI:    z2 <= prod[2*H-1:0];
        P_MID:   zm <= prod;
        COMBINE: begin
          Z    <= sum[2*WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
